morty_wb_ram_slave: RTL and testbench
=====================================

# morty_wb_ram_slave

Wishbone classic responder wrapping a word-organised RAM. It is the target side of the bus driven by the IF stage's fetch master and, through the same port, by the MEM stage's load/store master. It supports configurable wait states, byte-lane writes, abort on early strobe drop, and an optional error response for illegal addresses.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000: byte address of word 0.
- DEPTH_WORDS, 1024: number of 32-bit words; power of two, ≥ 2.
- WAIT_STATES, 1: extra cycles between request sample and response, 0..15.

Ports:
- clk_i, input, 1: clock; all state updates on rising edge.
- rst_i, input, 1: reset, asynchronous, active-high.
- wbs_addr_i, input, 32: byte address.
- wbs_dat_i, input, 32: write data.
- wbs_sel_i, input, 4: byte-lane enables; bit n selects bits [8n+7:8n].
- wbs_cyc_i, input, 1: bus cycle valid.
- wbs_stb_i, input, 1: strobe.
- wbs_we_i, input, 1: 1 for write, 0 for read.
- wbs_dat_o, output, 32: read data, registered.
- wbs_ack_o, output, 1: normal termination, registered, one-cycle pulse.
- wbs_err_o, output, 1: error termination, registered, one-cycle pulse.

## Operation
- Request is `req = wbs_cyc_i & wbs_stb_i`.
- The FSM has three states: IDLE, WAIT and RESP.
- **IDLE**
  - On req, latch addr, we, dat and sel.
  - Load cnt = WAIT_STATES.
  - Next state is WAIT if WAIT_STATES > 0, else RESP.
- **WAIT**
  - If !req, go to IDLE. This is an abort: no write, no ack/err.
  - Else decrement cnt; when cnt == 1, go to RESP.
- **Commit (edge entering RESP)**
  - Legal write: RAM lanes with sel = 1 are updated from the latched data; wbs_ack_o is set.
  - Legal read: wbs_dat_o ← RAM[index]; wbs_ack_o is set.
  - Illegal access: wbs_err_o is set, wbs_dat_o ← 0, no RAM change.
- **RESP**
  - ack or err is high for exactly this cycle.
  - Next state is IDLE unconditionally.
  - A request still held in RESP is not re-sampled; at least one IDLE cycle separates transactions.
- index = (addr − BASE_ADDR) >> 2, truncated to $clog2(DEPTH_WORDS) bits.
- wbs_dat_o holds its value until the next read or err commit. Writes and aborts leave it unchanged. A master may sample it in the cycle after ack.
- wbs_sel_i is ignored on reads; a full word is always returned.
- The legality check is defined under Configuration.

## Timing
- Reset (async assert): state = IDLE, cnt = 0, wbs_ack_o = 0, wbs_err_o = 0, wbs_dat_o = 0. RAM contents are not reset.
- Reset asserted mid-transaction discards it: no write, no response.
- Latency: req first high in cycle N (in IDLE) → ack/err high in cycle N + 1 + WAIT_STATES.
- Cycle period for a master that drops stb for one cycle after ack: WAIT_STATES + 3 cycles.
- ack and err are never high simultaneously and never high without req in the preceding cycle.
- Write visibility: a read whose commit falls strictly after a write's commit returns the new data.

## Configuration
- WB_SLAVE_ERR_EN defined:
  - An access is illegal if addr[1:0] ≠ 0 or addr is outside [BASE_ADDR, BASE_ADDR + 4·DEPTH_WORDS).
  - An illegal access gets an err response as described above.
- Not defined:
  - Every access is legal; wbs_err_o is tied to 0.
  - addr[1:0] is ignored and the index wraps modulo DEPTH_WORDS.

## Structure
- morty_wb_pkg holds:
  - the state enum (IDLE/RESP/WAIT encoded 2'b00/2'b01/2'b10);
  - a WB_DW = 32 constant;
  - a WB_SELW = 4 constant;
  - an addr-in-range function reused by future slaves.
- Sub-module morty_wb_ram_array:
  - 32-bit × DEPTH_WORDS storage;
  - per-byte write enable;
  - synchronous read port.
- The FSM, counter and decode stay in the top module.

## Test plan
- **Zero-wait read:** WAIT_STATES = 0, RAM[0] = 32'hDEAD_BEEF, read addr 0x0 → ack in cycle N+1, wbs_dat_o = 32'hDEAD_BEEF, held in cycle N+2.
- **Byte-lane write:** WAIT_STATES = 3, RAM[1] = 32'h1122_3344, write 32'hAABB_CCDD to addr 0x4 with sel 4'b0101, then read 0x4 → ack at N+4, read returns 32'h11BB_33DD.
- **Abort:** drop stb in the second WAIT cycle of a write to 0x8 → no ack/err, RAM[2] unchanged, FSM in IDLE next cycle.
- **Error (WB_SLAVE_ERR_EN):**
  - read 0x2 → err pulse, wbs_dat_o = 0;
  - write BASE_ADDR + 4·DEPTH_WORDS → err, no RAM change.
  - Without the macro, the same write wraps to word 0 and acks.
- **Reset mid-operation:** assert rst_i asynchronously during WAIT of a write → outputs 0 immediately, RAM unchanged, the next transaction behaves normally.
- **IF-master pattern:** back-to-back fetches from 0x0, 0x4, 0x8 with stb dropped one cycle after each ack → three acks with period WAIT_STATES + 3, correct words returned.

Source files
------------

// File: rtl/morty_wb_pkg.sv
// Shared Wishbone slave types, widths and address helpers.
// Imported by the RAM slave top and its storage array.
package morty_wb_pkg;

  localparam int WB_DW   = 32;
  localparam int WB_SELW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RESP = 2'b01,
    WAIT = 2'b10
  } wb_state_e;

  function automatic logic addr_in_range(
    input logic [31:0] addr,
    input logic [31:0] base,
    input logic [32:0] size
  );
    logic [32:0] a;
    logic [32:0] lo;
    logic [32:0] hi;
    a  = {1'b0, addr};
    lo = {1'b0, base};
    hi = lo + size;
    return (a >= lo) && (a < hi);
  endfunction

endpackage

// File: rtl/morty_wb_ram_array.sv
// Word-organised RAM, byte-lane writes, registered read port.
// Contents are never reset; only the read register is.
module morty_wb_ram_array
  import morty_wb_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               we_i,
  input  logic [WB_SELW-1:0] be_i,
  input  logic [AW-1:0]      addr_i,
  input  logic [WB_DW-1:0]   wdat_i,
  output logic [WB_DW-1:0]   rdat_o
);

  logic [WB_DW-1:0] mem [DEPTH_WORDS];

  // byte-lane write into storage
  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      for (int b = 0; b < WB_SELW; b++) begin
        if (be_i[b]) begin
          mem[addr_i][8*b +: 8] <= wdat_i[8*b +: 8];
        end
      end
    end
  end

  // read register updates only on a read access
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdat_o <= '0;
    end else if (en_i && !we_i) begin
      rdat_o <= mem[addr_i];
    end
  end

endmodule

// File: rtl/morty_wb_ram_slave.sv
// Wishbone classic RAM responder with wait states and abort.
// Define WB_SLAVE_ERR_EN for err on misaligned/out-of-range access.
module morty_wb_ram_slave
  import morty_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [31:0]        wbs_addr_i,
  input  logic [WB_DW-1:0]   wbs_dat_i,
  input  logic [WB_SELW-1:0] wbs_sel_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_we_i,
  output logic [WB_DW-1:0]   wbs_dat_o,
  output logic               wbs_ack_o,
  output logic               wbs_err_o
);

  localparam int         AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  wb_state_e state_q;
  wb_state_e state_d;

  logic               req;
  logic [3:0]         cnt_q;
  logic [31:0]        addr_q;
  logic [WB_DW-1:0]   dat_q;
  logic [WB_SELW-1:0] sel_q;
  logic               we_q;

  logic load;
  logic dec;
  logic commit;
  logic use_live;

  logic [31:0]        c_addr;
  logic [WB_DW-1:0]   c_dat;
  logic [WB_SELW-1:0] c_sel;
  logic               c_we;
  logic [31:0]        c_off;
  logic [AW-1:0]      c_idx;
  logic               illegal;
  logic               unused_off;

  logic               ack_q;
  logic               err_q;
  logic               zero_q;
  logic [WB_DW-1:0]   rd_dat;

  assign req = wbs_cyc_i & wbs_stb_i;

  // state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d = (WS == 4'd0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (!req) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd1) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // per-state control strobes
  always_comb begin
    load     = 1'b0;
    dec      = 1'b0;
    commit   = 1'b0;
    use_live = 1'b0;
    unique case (state_q)
      IDLE: begin
        load     = req;
        use_live = 1'b1;
        commit   = req && (WS == 4'd0);
      end
      WAIT: begin
        dec    = req;
        commit = req && (cnt_q == 4'd1);
      end
      default: ;
    endcase
  end

  // zero-wait commits straight from the bus, otherwise from the latch
  assign c_addr = use_live ? wbs_addr_i : addr_q;
  assign c_dat  = use_live ? wbs_dat_i  : dat_q;
  assign c_sel  = use_live ? wbs_sel_i  : sel_q;
  assign c_we   = use_live ? wbs_we_i   : we_q;

  assign c_off      = c_addr - BASE_ADDR;
  assign c_idx      = c_off[AW+1:2];
  assign unused_off = ^c_off;

`ifdef WB_SLAVE_ERR_EN
  localparam logic [32:0] SPAN = 33'(4 * DEPTH_WORDS);
  assign illegal = (c_addr[1:0] != 2'b00) ||
                   !addr_in_range(c_addr, BASE_ADDR, SPAN);
`else
  assign illegal = 1'b0;
`endif

  // request latch, captured on accept in IDLE
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q <= '0;
      dat_q  <= '0;
      sel_q  <= '0;
      we_q   <= 1'b0;
    end else if (load) begin
      addr_q <= wbs_addr_i;
      dat_q  <= wbs_dat_i;
      sel_q  <= wbs_sel_i;
      we_q   <= wbs_we_i;
    end
  end

  // wait-state counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= WS;
    end else if (dec) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // response pulses and read-data zeroing on err
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      ack_q <= commit & ~illegal;
      err_q <= commit &  illegal;
      if (commit && illegal) begin
        zero_q <= 1'b1;
      end else if (commit && !c_we) begin
        zero_q <= 1'b0;
      end
    end
  end

  morty_wb_ram_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (commit & ~illegal),
    .we_i  (c_we),
    .be_i  (c_sel),
    .addr_i(c_idx),
    .wdat_i(c_dat),
    .rdat_o(rd_dat)
  );

  assign wbs_dat_o = zero_q ? '0 : rd_dat;
  assign wbs_ack_o = ack_q;
  assign wbs_err_o = err_q;

endmodule

// File: tb/tb_morty_wb_ram_slave.sv
// Bench for morty_wb_ram_slave: WAIT_STATES 0 and 3 instances.
// Expected responses are queued at issue and checked on ack/err.
module tb_morty_wb_ram_slave;

  typedef struct {
    logic        err;
    logic [31:0] dat;
  } exp_t;

  typedef struct {
    int          k;
    logic        we;
    logic [31:0] addr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] addr_s [2];
  logic [31:0] dat_s  [2];
  logic [3:0]  sel_s  [2];
  logic        cyc_s  [2];
  logic        stb_s  [2];
  logic        we_s   [2];
  logic [31:0] rdat   [2];
  logic        ack    [2];
  logic        err    [2];

  int          checks   = 0;
  int          failures = 0;
  int          cyc_n    = 0;
  logic [31:0] last [2];
  exp_t        q0 [$];
  exp_t        q1 [$];
  vec_t        tbl [14];

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc_n <= cyc_n + 1;

  morty_wb_ram_slave #(
    .BASE_ADDR(32'h0), .DEPTH_WORDS(16), .WAIT_STATES(0)
  ) u_ws0 (
    .clk_i(clk_i), .rst_i(rst_i),
    .wbs_addr_i(addr_s[0]), .wbs_dat_i(dat_s[0]),
    .wbs_sel_i(sel_s[0]), .wbs_cyc_i(cyc_s[0]),
    .wbs_stb_i(stb_s[0]), .wbs_we_i(we_s[0]),
    .wbs_dat_o(rdat[0]), .wbs_ack_o(ack[0]),
    .wbs_err_o(err[0])
  );

  morty_wb_ram_slave #(
    .BASE_ADDR(32'h0), .DEPTH_WORDS(16), .WAIT_STATES(3)
  ) u_ws3 (
    .clk_i(clk_i), .rst_i(rst_i),
    .wbs_addr_i(addr_s[1]), .wbs_dat_i(dat_s[1]),
    .wbs_sel_i(sel_s[1]), .wbs_cyc_i(cyc_s[1]),
    .wbs_stb_i(stb_s[1]), .wbs_we_i(we_s[1]),
    .wbs_dat_o(rdat[1]), .wbs_ack_o(ack[1]),
    .wbs_err_o(err[1])
  );

  function automatic int ws(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push(input int k, input logic we,
                      input logic exp_err,
                      input logic [31:0] exp_rd);
    exp_t e;
    e.err = exp_err;
    if (exp_err)  e.dat = 32'h0;
    else if (!we) e.dat = exp_rd;
    else          e.dat = last[k];
    last[k] = e.dat;
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic do_txn(input int k, input logic we,
                        input logic [31:0] addr,
                        input logic [31:0] dat,
                        input logic [3:0] sel,
                        input logic exp_err,
                        input logic [31:0] exp_rd,
                        output int ack_at);
    int   n;
    exp_t d;
    push(k, we, exp_err, exp_rd);
    @(posedge clk_i); #1;
    addr_s[k] = addr; dat_s[k] = dat; sel_s[k] = sel;
    we_s[k] = we; cyc_s[k] = 1'b1; stb_s[k] = 1'b1;
    n = 0;
    do begin
      @(posedge clk_i); #1;
      n++;
    end while (!(ack[k] || err[k]) && n < 40);
    ack_at = cyc_n;
    chk($sformatf("latency[%0d]@%h", k, addr), n, ws(k) + 1);
    if (!(ack[k] || err[k])) begin
      if (k == 0 && q0.size() > 0) d = q0.pop_back();
      if (k == 1 && q1.size() > 0) d = q1.pop_back();
    end
    @(posedge clk_i); #1;
    cyc_s[k] = 1'b0; stb_s[k] = 1'b0;
  endtask

  // response monitor
  always @(negedge clk_i) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_i && (ack[k] || err[k])) begin
        exp_t e;
        chk($sformatf("ack_err_excl[%0d]", k),
            {31'b0, ack[k] & err[k]}, 32'd0);
        if ((k == 0 && q0.size() == 0) ||
            (k == 1 && q1.size() == 0)) begin
          chk($sformatf("unexpected_resp[%0d]", k), 32'd1, 32'd0);
        end else begin
          if (k == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          chk($sformatf("resp_err[%0d]", k), {31'b0, err[k]},
              {31'b0, e.err});
          chk($sformatf("resp_dat[%0d]", k), rdat[k], e.dat);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   a0, a1, a2, t;
    logic flag;
    for (int k = 0; k < 2; k++) begin
      addr_s[k] = '0; dat_s[k] = '0; sel_s[k] = '0;
      cyc_s[k] = 1'b0; stb_s[k] = 1'b0; we_s[k] = 1'b0;
      last[k] = '0;
    end

    tbl[0]  = '{1, 1'b1, 32'h00, 32'h1357_9BDF, 4'hF, 1'b0, 32'h0};
    tbl[1]  = '{1, 1'b1, 32'h04, 32'h1122_3344, 4'hF, 1'b0, 32'h0};
    tbl[2]  = '{1, 1'b1, 32'h04, 32'hAABB_CCDD, 4'h5, 1'b0, 32'h0};
    tbl[3]  = '{1, 1'b0, 32'h04, 32'h0,         4'h0, 1'b0, 32'h11BB_33DD};
    tbl[4]  = '{1, 1'b1, 32'h08, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0};
    tbl[5]  = '{1, 1'b1, 32'h08, 32'h0000_1200, 4'h2, 1'b0, 32'h0};
    tbl[6]  = '{1, 1'b0, 32'h08, 32'h0,         4'hF, 1'b0, 32'hCAFE_120D};
    tbl[7]  = '{1, 1'b1, 32'h0C, 32'h0BAD_C0DE, 4'hF, 1'b0, 32'h0};
    tbl[8]  = '{1, 1'b1, 32'h3C, 32'h0123_4567, 4'hF, 1'b0, 32'h0};
    tbl[9]  = '{1, 1'b1, 32'h3C, 32'h89AB_CDEF, 4'h8, 1'b0, 32'h0};
    tbl[10] = '{1, 1'b0, 32'h3C, 32'h0,         4'hF, 1'b0, 32'h8923_4567};
    tbl[11] = '{0, 1'b1, 32'h00, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0};
    tbl[12] = '{0, 1'b0, 32'h00, 32'h0,         4'hF, 1'b0, 32'hDEAD_BEEF};
    tbl[13] = '{1, 1'b0, 32'h0C, 32'h0,         4'hF, 1'b0, 32'h0BAD_C0DE};

    #1 rst_i = 1'b1;
    #2;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_ack[%0d]", k), {31'b0, ack[k]}, 32'd0);
      chk($sformatf("rst_err[%0d]", k), {31'b0, err[k]}, 32'd0);
      chk($sformatf("rst_dat[%0d]", k), rdat[k], 32'd0);
    end
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;

    for (int i = 0; i < 14; i++) begin
      do_txn(tbl[i].k, tbl[i].we, tbl[i].addr, tbl[i].dat,
             tbl[i].sel, tbl[i].exp_err, tbl[i].exp_rd, t);
    end
    chk("dat_hold_ws0", rdat[0], 32'hDEAD_BEEF);

    // abort: strobe dropped in the second WAIT cycle
    @(posedge clk_i); #1;
    addr_s[1] = 32'h8; dat_s[1] = 32'h0; sel_s[1] = 4'hF;
    we_s[1] = 1'b1; cyc_s[1] = 1'b1; stb_s[1] = 1'b1;
    flag = 1'b0;
    @(posedge clk_i); #1;
    flag |= ack[1] | err[1];
    @(posedge clk_i); #1;
    flag |= ack[1] | err[1];
    stb_s[1] = 1'b0;
    repeat (5) begin
      @(posedge clk_i); #1;
      flag |= ack[1] | err[1];
    end
    cyc_s[1] = 1'b0;
    chk("abort_no_resp", {31'b0, flag}, 32'd0);
    do_txn(1, 1'b0, 32'h8, 32'h0, 4'hF, 1'b0, 32'hCAFE_120D, t);

    // fetch pattern: period must be WAIT_STATES + 3
    do_txn(1, 1'b0, 32'h0, 32'h0, 4'hF, 1'b0, 32'h1357_9BDF, a0);
    do_txn(1, 1'b0, 32'h4, 32'h0, 4'hF, 1'b0, 32'h11BB_33DD, a1);
    do_txn(1, 1'b0, 32'h8, 32'h0, 4'hF, 1'b0, 32'hCAFE_120D, a2);
    chk("fetch_period_1", a1 - a0, 32'd6);
    chk("fetch_period_2", a2 - a1, 32'd6);

    // reset asserted during WAIT of a write
    @(posedge clk_i); #1;
    addr_s[1] = 32'hC; dat_s[1] = 32'hFFFF_FFFF; sel_s[1] = 4'hF;
    we_s[1] = 1'b1; cyc_s[1] = 1'b1; stb_s[1] = 1'b1;
    @(posedge clk_i); #1;
    #3 rst_i = 1'b1;
    #1;
    chk("midrst_ack", {31'b0, ack[1]}, 32'd0);
    chk("midrst_err", {31'b0, err[1]}, 32'd0);
    chk("midrst_dat1", rdat[1], 32'd0);
    chk("midrst_dat0", rdat[0], 32'd0);
    last[0] = '0;
    last[1] = '0;
    @(posedge clk_i); #1;
    cyc_s[1] = 1'b0; stb_s[1] = 1'b0;
    rst_i = 1'b0;
    do_txn(1, 1'b0, 32'hC, 32'h0, 4'hF, 1'b0, 32'h0BAD_C0DE, t);

    // illegal addresses on the zero-wait instance
`ifdef WB_SLAVE_ERR_EN
    do_txn(0, 1'b1, 32'h40, 32'h5555_AAAA, 4'hF, 1'b1, 32'h0, t);
    do_txn(0, 1'b0, 32'h00, 32'h0, 4'hF, 1'b0, 32'hDEAD_BEEF, t);
    do_txn(0, 1'b0, 32'h02, 32'h0, 4'hF, 1'b1, 32'h0, t);
    chk("err_dat_zero", rdat[0], 32'd0);
`else
    do_txn(0, 1'b1, 32'h40, 32'h5555_AAAA, 4'hF, 1'b0, 32'h0, t);
    do_txn(0, 1'b0, 32'h00, 32'h0, 4'hF, 1'b0, 32'h5555_AAAA, t);
    do_txn(0, 1'b0, 32'h02, 32'h0, 4'hF, 1'b0, 32'h5555_AAAA, t);
    chk("wrap_dat", rdat[0], 32'h5555_AAAA);
`endif

    repeat (4) @(posedge clk_i);
    #1;
    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
